// File: rtl/pipe_pkg.sv
// Shared types and default widths for the EX->MEM pipeline boundary.
package pipe_pkg;

    localparam int DATA_W = 32;
    localparam int RD_W   = 5;
    localparam int M_W    = 4;
    localparam int WB_W   = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

    // Default-width payload; the register module rebuilds the same layout from its own parameters.
    typedef struct packed {
        logic              zero;
        logic [DATA_W-1:0] result;
        logic [DATA_W-1:0] write_data;
        logic [RD_W-1:0]   rd;
        logic [M_W-1:0]    ctrl_m;
        logic [WB_W-1:0]   ctrl_wb;
    } ex_mem_payload_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; shared by the stall counter and perf counters.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/ex_mem_skid_reg.sv
// EX->MEM boundary register: two-entry skid buffer so in_ready never depends
// combinationally on out_ready, plus flush and a saturating stall counter.
module ex_mem_skid_reg #(
    parameter int DATA_W = pipe_pkg::DATA_W,
    parameter int RD_W   = pipe_pkg::RD_W,
    parameter int M_W    = pipe_pkg::M_W,
    parameter int WB_W   = pipe_pkg::WB_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_zero,
    input  logic [DATA_W-1:0] in_result,
    input  logic [DATA_W-1:0] in_write_data,
    input  logic [RD_W-1:0]   in_rd,
    input  logic [M_W-1:0]    in_ctrl_m,
    input  logic [WB_W-1:0]   in_ctrl_wb,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_zero,
    output logic [DATA_W-1:0] out_result,
    output logic [DATA_W-1:0] out_write_data,
    output logic [RD_W-1:0]   out_rd,
    output logic [M_W-1:0]    out_ctrl_m,
    output logic [WB_W-1:0]   out_ctrl_wb,
    output logic [CNT_W-1:0]  stall_cnt
);

    import pipe_pkg::*;

    typedef struct packed {
        logic              zero;
        logic [DATA_W-1:0] result;
        logic [DATA_W-1:0] write_data;
        logic [RD_W-1:0]   rd;
        logic [M_W-1:0]    ctrl_m;
        logic [WB_W-1:0]   ctrl_wb;
    } payload_t;

    skid_state_e r_state;
    skid_state_e w_next_state;
    payload_t    r_main;
    payload_t    r_skid;
    payload_t    w_in_payload;
    payload_t    w_main_src;
    logic        w_in_xfer;
    logic        w_out_xfer;
    logic        w_load_main;
    logic        w_load_skid;
    logic        w_main_from_skid;

    assign in_ready   = (r_state != FULL);
    assign out_valid  = (r_state != EMPTY);
    assign w_in_xfer  = in_valid & in_ready;
    assign w_out_xfer = out_valid & out_ready;

    assign w_in_payload = '{zero: in_zero, result: in_result, write_data: in_write_data,
                            rd: in_rd, ctrl_m: in_ctrl_m, ctrl_wb: in_ctrl_wb};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (flush) begin
            w_next_state = EMPTY;
        end else begin
            case (r_state)
                EMPTY:   if (w_in_xfer) w_next_state = ONE;
                ONE: begin
                    if (w_in_xfer && !w_out_xfer) begin
                        w_next_state = FULL;
                    end else if (!w_in_xfer && w_out_xfer) begin
                        w_next_state = EMPTY;
                    end
                end
                FULL:    if (w_out_xfer) w_next_state = ONE;
                default: w_next_state = EMPTY;
            endcase
        end
    end

    // Flush suppresses every load; the stale payload is hidden by out_valid=0.
    always_comb begin
        w_load_main      = 1'b0;
        w_load_skid      = 1'b0;
        w_main_from_skid = 1'b0;
        if (!flush) begin
            case (r_state)
                EMPTY: w_load_main = w_in_xfer;
                ONE: begin
                    w_load_main = w_in_xfer & w_out_xfer;
                    w_load_skid = w_in_xfer & ~w_out_xfer;
                end
                FULL: begin
                    w_load_main      = w_out_xfer;
                    w_main_from_skid = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign w_main_src = w_main_from_skid ? r_skid : w_in_payload;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_main) r_main <= w_main_src;
            if (w_load_skid) r_skid <= w_in_payload;
        end
    end

    assign out_zero       = r_main.zero;
    assign out_result     = r_main.result;
    assign out_write_data = r_main.write_data;
    assign out_rd         = r_main.rd;
    assign out_ctrl_m     = r_main.ctrl_m & {M_W{out_valid}};
    assign out_ctrl_wb    = r_main.ctrl_wb & {WB_W{out_valid}};

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (out_valid & ~out_ready),
        .count (stall_cnt)
    );

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Randomised + directed bench for ex_mem_skid_reg, checked against a queue-based reference model.
module tb_ex_mem_skid_reg;

    import pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_zero = 1'b0;
    logic [31:0] in_result = '0;
    logic [31:0] in_write_data = '0;
    logic [4:0]  in_rd = '0;
    logic [3:0]  in_ctrl_m = '0;
    logic [1:0]  in_ctrl_wb = '0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, out_zero;
    logic [31:0] out_result, out_write_data;
    logic [4:0]  out_rd;
    logic [3:0]  out_ctrl_m;
    logic [1:0]  out_ctrl_wb;
    logic [15:0] stall_cnt;

    logic        in_ready4, out_valid4, out_zero4;
    logic [31:0] out_result4, out_write_data4;
    logic [4:0]  out_rd4;
    logic [3:0]  out_ctrl_m4;
    logic [1:0]  out_ctrl_wb4;
    logic [3:0]  stall_cnt4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_mem_skid_reg dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_zero(in_zero), .in_result(in_result), .in_write_data(in_write_data),
        .in_rd(in_rd), .in_ctrl_m(in_ctrl_m), .in_ctrl_wb(in_ctrl_wb),
        .out_valid(out_valid), .out_ready(out_ready), .out_zero(out_zero),
        .out_result(out_result), .out_write_data(out_write_data), .out_rd(out_rd),
        .out_ctrl_m(out_ctrl_m), .out_ctrl_wb(out_ctrl_wb), .stall_cnt(stall_cnt)
    );

    ex_mem_skid_reg #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready4),
        .in_zero(in_zero), .in_result(in_result), .in_write_data(in_write_data),
        .in_rd(in_rd), .in_ctrl_m(in_ctrl_m), .in_ctrl_wb(in_ctrl_wb),
        .out_valid(out_valid4), .out_ready(out_ready), .out_zero(out_zero4),
        .out_result(out_result4), .out_write_data(out_write_data4), .out_rd(out_rd4),
        .out_ctrl_m(out_ctrl_m4), .out_ctrl_wb(out_ctrl_wb4), .stall_cnt(stall_cnt4)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a FIFO of held instructions (capacity 2) and plain saturating counts.
    ex_mem_payload_t heldQ[$];
    int  modelStall16 = 0;
    int  modelStall4  = 0;
    bit  armed = 1'b0;
    int  occ;
    ex_mem_payload_t inItem;

    always @(posedge clk) begin
        if (rst) begin
            heldQ.delete();
            modelStall16 = 0;
            modelStall4  = 0;
            armed = 1'b1;
        end else begin
            occ = heldQ.size();
            if (occ > 0 && !out_ready) begin
                if (modelStall16 < 65535) modelStall16++;
                if (modelStall4 < 15) modelStall4++;
            end
            if (flush) begin
                heldQ.delete();
            end else begin
                inItem = '{zero: in_zero, result: in_result, write_data: in_write_data,
                           rd: in_rd, ctrl_m: in_ctrl_m, ctrl_wb: in_ctrl_wb};
                if (occ > 0 && out_ready) void'(heldQ.pop_front());
                if (in_valid && occ < 2) heldQ.push_back(inItem);
            end
        end
    end

    // Monitor: compares presented outputs against the model head each cycle.
    always @(negedge clk) begin
        if (armed) begin
            checkOutput("out_valid", 64'(out_valid), 64'(heldQ.size() > 0));
            checkOutput("in_ready", 64'(in_ready), 64'(heldQ.size() < 2));
            checkOutput("out_valid4", 64'(out_valid4), 64'(heldQ.size() > 0));
            checkOutput("stall_cnt", 64'(stall_cnt), 64'(modelStall16));
            checkOutput("stall_cnt4", 64'(stall_cnt4), 64'(modelStall4));
            if (heldQ.size() > 0) begin
                checkOutput("out_zero", 64'(out_zero), 64'(heldQ[0].zero));
                checkOutput("out_result", 64'(out_result), 64'(heldQ[0].result));
                checkOutput("out_write_data", 64'(out_write_data), 64'(heldQ[0].write_data));
                checkOutput("out_rd", 64'(out_rd), 64'(heldQ[0].rd));
                checkOutput("out_ctrl_m", 64'(out_ctrl_m), 64'(heldQ[0].ctrl_m));
                checkOutput("out_ctrl_wb", 64'(out_ctrl_wb), 64'(heldQ[0].ctrl_wb));
            end else begin
                checkOutput("bubble_ctrl_m", 64'(out_ctrl_m), 64'd0);
                checkOutput("bubble_ctrl_wb", 64'(out_ctrl_wb), 64'd0);
            end
        end
    end

    task automatic applyStimulus(input logic v, input logic rdy, input logic fl,
                                 input logic [31:0] res, input logic [3:0] cm, input logic [1:0] cwb);
        @(negedge clk);
        #1;
        in_valid      = v;
        out_ready     = rdy;
        flush         = fl;
        in_result     = res;
        in_ctrl_m     = cm;
        in_ctrl_wb    = cwb;
        in_zero       = 1'($urandom);
        in_write_data = $urandom;
        in_rd         = 5'($urandom);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_out_result", 64'(out_result), 64'd0);
        checkOutput("reset_out_write_data", 64'(out_write_data), 64'd0);
        checkOutput("reset_out_rd", 64'(out_rd), 64'd0);
        checkOutput("reset_out_zero", 64'(out_zero), 64'd0);
        #1 rst = 1'b0;

        // Streaming: one per cycle with out_ready held high.
        for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'(i), 4'(i), 2'(i));
        repeat (2) applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 4'd0, 2'd0);

        // Back-pressure: A and B fill both entries, C must be dropped.
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h11, 4'h1, 2'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h22, 4'h2, 2'd2);
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 32'h33, 4'h3, 2'd3);
        repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 4'd0, 2'd0);

        // Flush while FULL with D presented.
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h55, 4'h5, 2'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h66, 4'h6, 2'd2);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h44, 4'hF, 2'd3);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 2'd0);
        checkOutput("flush_out_valid", 64'(out_valid), 64'd0);
        checkOutput("flush_in_ready", 64'(in_ready), 64'd1);
        repeat (2) applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 4'd0, 2'd0);

        // Bubble gating after a RegWrite-style instruction drains.
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h77, 4'hF, 2'b11);
        repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 4'd0, 2'd0);

        // Saturation of the 4-bit stall counter.
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h88, 4'h8, 2'd1);
        repeat (20) applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 2'd0);
        @(negedge clk);
        checkOutput("sat_stall_cnt4", 64'(stall_cnt4), 64'd15);
        repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 4'd0, 2'd0);

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 79) == 0);
            applyStimulus(1'($urandom), ($urandom_range(0, 9) < 6), ($urandom_range(0, 15) == 0),
                          $urandom, 4'($urandom), 2'($urandom));
        end
        rst = 1'b0;
        repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 4'd0, 2'd0);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
